// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Define MULDIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub_w.sv
// WIDTH+1-bit adder/subtractor shared by the Booth and restoring-divide steps.
// o_co is the true carry out; on subtract it is 1 when i_x >= i_y (unsigned).
module add_sub_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] i_x,
    input  logic [WIDTH:0] i_y,
    input  logic           i_sub,
    output logic [WIDTH:0] o_sum,
    output logic           o_co
);

    logic [WIDTH:0] w_y;

    assign w_y = i_sub ? ~i_y : i_y;
    assign {o_co, o_sum} = {1'b0, i_x} + {1'b0, w_y} + {{(WIDTH + 1){1'b0}}, i_sub};

endmodule

// File: rtl/mul_div_unit.sv
// Radix-2 sequential multiply/divide, one step per cycle, WIDTH steps per op.
// MULDIV_SIGNED_EN selects two's-complement (Booth mul, sign-fixed divide).
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_op;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [WIDTH-1:0]   r_m;
    logic               r_negq, r_negr, r_dbz;
    logic [2*WIDTH-1:0] r_result;

    logic               w_div0, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_x, w_y, w_sum, w_rsh, w_base, w_acc_nxt;
    logic               w_sub, w_co, w_mul_en, w_mul_sub;
    logic [WIDTH-1:0]   w_q_nxt, w_rem, w_quo;
    logic [2*WIDTH-1:0] w_res_fin;

    assign w_div0  = (op == OP_DIV) && (b == '0);
    assign w_a_neg = SIGNED_EN & a[WIDTH-1];
    assign w_b_neg = SIGNED_EN & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Booth recodes {q0, q-1} in signed mode; unsigned mode is plain add-shift.
    assign w_mul_en  = SIGNED_EN ? (r_q[0] ^ r_qm1) : r_q[0];
    assign w_mul_sub = SIGNED_EN & r_q[0] & ~r_qm1;
    assign w_rsh     = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};

    always_comb begin
        w_x   = r_acc;
        w_y   = {SIGNED_EN & r_m[WIDTH-1], r_m};
        w_sub = w_mul_sub;
        if (r_op == OP_DIV) begin
            w_x   = w_rsh;
            w_y   = {1'b0, r_m};
            w_sub = 1'b1;
        end
    end

    add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
        .i_x   (w_x),
        .i_y   (w_y),
        .i_sub (w_sub),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    assign w_base = w_mul_en ? w_sum : r_acc;

    always_comb begin
        w_acc_nxt = {SIGNED_EN & w_base[WIDTH], w_base[WIDTH:1]};
        w_q_nxt   = {w_base[0], r_q[WIDTH-1:1]};
        if (r_op == OP_DIV) begin
            // Restoring step: keep the difference only when it did not borrow.
            w_acc_nxt = w_co ? w_sum : w_rsh;
            w_q_nxt   = {r_q[WIDTH-2:0], w_co};
        end
    end

    assign w_rem = r_negr ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    assign w_quo = r_negq ? -w_q_nxt : w_q_nxt;
    assign w_res_fin = (r_op == OP_DIV) ? {w_rem, w_quo} : {w_acc_nxt[WIDTH-1:0], w_q_nxt};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_div0 ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_dbz    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_cnt <= CW'(WIDTH - 1);
                        r_acc <= '0;
                        r_qm1 <= 1'b0;
                        r_dbz <= w_div0;
                        if (op == OP_MUL) begin
                            r_q    <= b;
                            r_m    <= a;
                            r_negq <= 1'b0;
                            r_negr <= 1'b0;
                        end else begin
                            r_q    <= w_a_mag;
                            r_m    <= w_b_mag;
                            r_negq <= w_a_neg ^ w_b_neg;
                            r_negr <= w_a_neg;
                        end
                        if (w_div0) r_result <= {a, {WIDTH{1'b1}}};
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[0];
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    else             r_result <= w_res_fin;
                end
                default: ;
            endcase
        end
    end

    assign result      = r_result;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; expectations follow MULDIV_SIGNED_EN.
module tb_mul_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic           start = 1'b0;
    logic           op = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, dbz;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    int lat;
    int ndone;
    int first_done;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (dbz)
    );

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {63'd0, busy}, 64'd0);
    endtask

    // lat counts rising edges from the accepting edge to the one that raises done.
    task automatic run_op(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          output int lat_o);
        wait_idle();
        op = op_i; a = a_i; b = b_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat_o = 1;
        while (!done && lat_o < 100) begin
            @(posedge clk); #1;
            lat_o++;
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_dbz", {63'd0, dbz}, 64'd0);
        @(negedge clk);
        clr = 1'b1;

        run_op(1'b0, 32'd7, 32'd6, lat);
        chk("mul7x6_lat", 64'(lat), 64'd33);
        chk("mul7x6_res", result, 64'd42);
        chk("mul7x6_dbz", {63'd0, dbz}, 64'd0);
        @(posedge clk); #1;
        chk("mul7x6_done_pulse", {63'd0, done}, 64'd0);
        chk("mul7x6_idle", {63'd0, busy}, 64'd0);

        run_op(1'b0, 32'hFFFF_FFFD, 32'd5, lat);
        chk("mul_m3x5_lat", 64'(lat), 64'd33);
`ifdef MULDIV_SIGNED_EN
        chk("mul_m3x5_res", result, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        chk("mul_m3x5_res", result, 64'h0000_0004_FFFF_FFF1);
`endif

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
`ifdef MULDIV_SIGNED_EN
        chk("mul_ones_res", result, 64'h0000_0000_0000_0001);
`else
        chk("mul_ones_res", result, 64'hFFFF_FFFE_0000_0001);
`endif

        run_op(1'b1, 32'd100, 32'd7, lat);
        chk("div100_7_lat", 64'(lat), 64'd33);
        chk("div100_7_res", result, {32'd2, 32'd14});
        chk("div100_7_dbz", {63'd0, dbz}, 64'd0);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
`ifdef MULDIV_SIGNED_EN
        chk("div_m7_2_res", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
        chk("div_m7_2_res", result, {32'd1, 32'h7FFF_FFFC});
`endif

        run_op(1'b1, 32'd3, 32'd10, lat);
        chk("div3_10_res", result, {32'd3, 32'd0});

        run_op(1'b1, 32'd9, 32'd0, lat);
        chk("div0_lat", 64'(lat), 64'd1);
        chk("div0_dbz", {63'd0, dbz}, 64'd1);
        chk("div0_res", result, {32'd9, 32'hFFFF_FFFF});
        @(posedge clk); #1;
        chk("div0_done_pulse", {63'd0, done}, 64'd0);
        chk("div0_idle", {63'd0, busy}, 64'd0);

        // Abort a multiply mid-run with clr.
        wait_idle();
        op = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_result_hold", result, {32'd9, 32'hFFFF_FFFF});
        chk("run_dbz_cleared", {63'd0, dbz}, 64'd0);
        clr = 1'b0;
        #1;
        chk("clr_busy", {63'd0, busy}, 64'd0);
        chk("clr_done", {63'd0, done}, 64'd0);
        chk("clr_result", result, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        run_op(1'b0, 32'd3, 32'd3, lat);
        chk("mul3x3_lat", 64'(lat), 64'd33);
        chk("mul3x3_res", result, 64'd9);

        // start held high; a changes after acceptance.
        wait_idle();
        op = 1'b0; a = 32'd2; b = 32'd2; start = 1'b1;
        ndone = 0;
        first_done = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 5) a = 32'd5;
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = i;
            end
            if (i == 33) chk("held_res", result, 64'd4);
            if (i == 34) chk("held_idle_after_done", {63'd0, busy}, 64'd0);
            if (i == 35) chk("held_reaccept", {63'd0, busy}, 64'd1);
            if (i == 40) chk("held_res_during_run", result, 64'd4);
        end
        start = 1'b0;
        chk("held_ndone", 64'(ndone), 64'd1);
        chk("held_done_cycle", 64'(first_done), 64'd33);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held_second_done", {63'd0, done}, 64'd1);
        chk("held_second_res", result, 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
